clock_div_sequencer: RTL and testbench

- Synthesizable divide-by-N clock-enable generator with a runtime-reprogrammable divisor.
- Sits between a config register (valid/ready) and a clock gate / divided-domain logic.
- Sequences divisor changes glitch-free: finishes the current period, holds the output gated for a fixed guard interval, loads the new divisor, then resumes.
- Duty cycle matches the team's divider convention: low for floor(N/2) cycles, high for ceil(N/2) cycles.

---
 rtl/clock_div_seq_pkg.sv | 10 +
 rtl/clock_div_core.sv | 34 +++
 rtl/clock_div_sequencer.sv | 84 ++++++++
 tb/tb_clock_div_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/clock_div_seq_pkg.sv
// clock_div_seq_pkg: shared state type, half-period helper and statistics widths for clock_div_sequencer
package clock_div_seq_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, GATE} seq_state_e;
  localparam int HALF_SHIFT = 1;
  localparam int RCFG_CNT_W = 16;
  localparam int ERR_CNT_W = 8;
  function automatic logic level_at(input logic [31:0] c, input logic [31:0] d);
    return c >= (d >> HALF_SHIFT);
  endfunction
endpackage

// File: rtl/clock_div_core.sv
// clock_div_core: divide-by-div counter with registered level/tick; ports clock, reset, hold, hold_level, div -> cnt, level, tick
module clock_div_core
  import clock_div_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int RESET_DIV = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          hold,
  input  logic          hold_level,
  input  logic [DW-1:0] div,
  output logic [DW-1:0] cnt,
  output logic          level,
  output logic          tick
);
  logic [DW-1:0] cnt_nx;
  logic          level_nx;
  always_comb begin
    cnt_nx = (hold || cnt == div - DW'(1)) ? '0 : cnt + DW'(1);
    level_nx = hold ? hold_level : level_at(32'(cnt_nx), 32'(div));
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
      level <= RESET_DIV == 1;
      tick <= 1'b0;
    end else begin
      cnt <= cnt_nx;
      level <= level_nx;
      tick <= !hold && level_nx && !level;
    end
  end
endmodule

// File: rtl/clock_div_sequencer.sv
// clock_div_sequencer: glitch-free reprogrammable clock-enable divider (drain, gate, load); cfg_* handshake in, div/en/busy/cur_div out; CLOCK_DIV_SEQ_STATS_EN adds reconfig_cnt_o/err_cnt_o
module clock_div_sequencer
  import clock_div_seq_pkg::*;
#(
  parameter int DW = 8,
  parameter int RESET_DIV = 2,
  parameter int GATE_CYCLES = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cfg_valid,
  input  logic [DW-1:0] cfg_div,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic          div_level_o,
  output logic          div_tick_o,
  output logic          en_o,
  output logic          busy_o,
  output logic [DW-1:0] cur_div_o
`ifdef CLOCK_DIV_SEQ_STATS_EN
  ,
  output logic [RCFG_CNT_W-1:0] reconfig_cnt_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
`endif
);
  localparam int GW = GATE_CYCLES > 1 ? $clog2(GATE_CYCLES) : 1;
  seq_state_e    state, state_nx;
  logic [DW-1:0] pend, pend_nx, cnt;
  logic [GW-1:0] gcnt;
  logic          acc, bnd, last_gate, hold, hold_level;
  assign cfg_ready = state == RUN && !reset;
  always_comb begin
    acc = cfg_valid && cfg_ready;
    bnd = cnt == cur_div_o - DW'(1);
    last_gate = gcnt == GW'(GATE_CYCLES - 1);
    pend_nx = (acc && cfg_div != '0) ? cfg_div : pend;
    state_nx = state == GATE  ? (last_gate ? RUN : GATE)
             : state == DRAIN ? (bnd ? GATE : DRAIN)
             : (acc && cfg_div != '0) ? (bnd ? GATE : DRAIN) : RUN;
    // hold covers the boundary cycle and every GATE cycle so the counter restarts at 0 under the new divisor
    hold = state == GATE || state_nx == GATE;
    hold_level = pend_nx == DW'(1);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      pend <= DW'(RESET_DIV);
      cur_div_o <= DW'(RESET_DIV);
      gcnt <= '0;
      en_o <= 1'b1;
      busy_o <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state <= state_nx;
      pend <= pend_nx;
      gcnt <= state == GATE ? gcnt + GW'(1) : '0;
      cur_div_o <= (state == GATE && last_gate) ? pend : cur_div_o;
      en_o <= state_nx != GATE;
      busy_o <= state_nx != RUN;
      cfg_err <= acc && cfg_div == '0;
    end
  end
  clock_div_core #(.DW(DW), .RESET_DIV(RESET_DIV)) u_core (
    .clock     (clock),
    .reset     (reset),
    .hold      (hold),
    .hold_level(hold_level),
    .div       (cur_div_o),
    .cnt       (cnt),
    .level     (div_level_o),
    .tick      (div_tick_o)
  );
`ifdef CLOCK_DIV_SEQ_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      reconfig_cnt_o <= '0;
      err_cnt_o <= '0;
    end else begin
      if (state == GATE && last_gate && !(&reconfig_cnt_o)) reconfig_cnt_o <= reconfig_cnt_o + RCFG_CNT_W'(1);
      if (cfg_err && !(&err_cnt_o)) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_clock_div_sequencer.sv
// tb_clock_div_sequencer: scoreboard bench comparing every cycle against a behavioural model of the divider sequence
module tb_clock_div_sequencer;
  import clock_div_seq_pkg::*;
  localparam int DW = 8, RST = 2, GC = 4;
  logic clock = 1'b0, reset = 1'b1, cfg_valid = 1'b0;
  logic [DW-1:0] cfg_div = '0;
  logic cfg_ready, cfg_err, div_level_o, div_tick_o, en_o, busy_o;
  logic [DW-1:0] cur_div_o;
  typedef struct packed {logic lvl, tick, en, busy, rdy, err; logic [DW-1:0] cur;} obs_t;
  obs_t sb[$];
  int cmp = 0, bad = 0;
  seq_state_e ms;
  int mc, md, mp, mg;
  logic ml;
  clock_div_sequencer #(.DW(DW), .RESET_DIV(RST), .GATE_CYCLES(GC)) dut (
    .clock(clock), .reset(reset), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .div_level_o(div_level_o), .div_tick_o(div_tick_o),
    .en_o(en_o), .busy_o(busy_o), .cur_div_o(cur_div_o)
  );
  always #5 clock = ~clock;
  function automatic obs_t got();
    return {div_level_o, div_tick_o, en_o, busy_o, cfg_ready, cfg_err, cur_div_o};
  endfunction
  task automatic step(input logic r, input logic v, input logic [DW-1:0] d);
    obs_t e;
    logic acc, bnd, nl;
    reset = r;
    cfg_valid = v;
    cfg_div = d;
    acc = v && ms == RUN && !r;
    e.err = acc && d == 0;
    if (r) begin
      ms = RUN; mc = 0; md = RST; nl = RST == 1;
    end else if (ms == GATE) begin
      if (mg == GC - 1) begin ms = RUN; md = mp; end else mg++;
      mc = 0;
      nl = ms == GATE ? mp == 1 : md == 1;
    end else begin
      bnd = mc == md - 1;
      if (acc && d != 0) begin mp = int'(d); ms = DRAIN; end
      mc = bnd ? 0 : mc + 1;
      if (ms == DRAIN && bnd) begin ms = GATE; mg = 0; end
      nl = ms == GATE ? mp == 1 : mc >= md / 2;
    end
    e.tick = !r && ms != GATE && nl && !ml;
    ml = nl;
    e.lvl = nl;
    e.en = ms != GATE;
    e.busy = ms != RUN;
    e.rdy = ms == RUN && !r;
    e.cur = DW'(md);
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    obs_t e;
    for (int i = 0; i < 8; i++) begin
      step(i == 0, 1'b0, '0);
      e = sb.pop_front(); cmp++;
      if (got() !== e) begin bad++; $display("FAIL reset cyc%0d got=%h want=%h", i, got(), e); end
    end
  endtask
  task automatic test_reconfig();
    obs_t e;
    logic sent = 1'b0, v;
    for (int i = 0; i < 24; i++) begin
      v = !sent && ms == RUN && mc == 0;
      sent |= v;
      step(1'b0, v, 8'd5);
      e = sb.pop_front(); cmp++;
      if (got() !== e) begin bad++; $display("FAIL reconfig cyc%0d got=%h want=%h", i, got(), e); end
    end
    if (!sent) begin bad++; $display("FAIL reconfig_issue got=0 want=1"); end
  endtask
  task automatic test_boundary();
    obs_t e;
    logic sent = 1'b0, v;
    for (int i = 0; i < 22; i++) begin
      v = !sent && ms == RUN && mc == md - 1;
      sent |= v;
      step(1'b0, v, 8'd3);
      e = sb.pop_front(); cmp++;
      if (got() !== e) begin bad++; $display("FAIL boundary cyc%0d got=%h want=%h", i, got(), e); end
    end
    if (!sent) begin bad++; $display("FAIL boundary_issue got=0 want=1"); end
  endtask
  task automatic test_err();
    obs_t e;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i == 1 || i == 2) && ms == RUN, '0);
      e = sb.pop_front(); cmp++;
      if (got() !== e) begin bad++; $display("FAIL cfg_err cyc%0d got=%h want=%h", i, got(), e); end
    end
  endtask
  task automatic test_ignore();
    obs_t e;
    logic sent = 1'b0, v;
    logic [DW-1:0] d;
    for (int i = 0; i < 24; i++) begin
      v = !sent || ms != RUN;
      d = sent ? 8'd9 : 8'd7;
      sent = 1'b1;
      step(1'b0, v, d);
      e = sb.pop_front(); cmp++;
      if (got() !== e) begin bad++; $display("FAIL ignore cyc%0d got=%h want=%h", i, got(), e); end
    end
  endtask
  task automatic test_div1();
    obs_t e;
    logic v;
    int n = 0;
    for (int i = 0; i < 32; i++) begin
      v = ms == RUN && n < 2 && (n == 0 || (md == 1 && i > 20));
      if (v) n++;
      step(1'b0, v, 8'd1);
      e = sb.pop_front(); cmp++;
      if (got() !== e) begin bad++; $display("FAIL div1 cyc%0d got=%h want=%h", i, got(), e); end
    end
    if (n != 2) begin bad++; $display("FAIL div1_issue got=%0d want=2", n); end
  endtask
  task automatic test_reset_gate();
    obs_t e;
    logic sent = 1'b0, rd = 1'b0, v, r;
    for (int i = 0; i < 16; i++) begin
      v = !sent && ms == RUN;
      r = sent && !rd && ms == GATE && mg == 1;
      sent |= v;
      rd |= r;
      step(r, v, 8'd7);
      e = sb.pop_front(); cmp++;
      if (got() !== e) begin bad++; $display("FAIL reset_gate cyc%0d got=%h want=%h", i, got(), e); end
    end
    if (!rd) begin bad++; $display("FAIL reset_gate_issue got=0 want=1"); end
  endtask
  initial begin
    test_reset();
    test_reconfig();
    test_boundary();
    test_err();
    test_ignore();
    test_div1();
    test_reset_gate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
